ysyx_220066_membus_arb: RTL and testbench

- Shares the single core memory port between instruction fetch (IF side, read-only) and the M-stage data side (load/store).
- One transaction outstanding at a time.
- Request fields are latched so the memory side sees stable signals.
- Data side has fixed priority, with a starvation counter that guarantees fetch progress.
- An IF kill (taken jump / CSR redirect) discards an in-flight fetch response.

---
 rtl/ysyx_220066_membus_arb_if.sv | 51 +++++
 rtl/ysyx_220066_membus_arb.sv | 151 +++++++++++++++
 tb/tb_ysyx_220066_membus_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_membus_arb_if.sv
// Bus bundle shared by the fetch side, the data side and the memory port.
// slave = arbiter view, master = surrounding core/memory view.
interface ysyx_220066_membus_arb_if #(
   parameter int ADDR_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_kill;
   logic              if_ready;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_err;

   logic              d_req;
   logic              d_wr;
   logic [2:0]        d_op;
   logic [ADDR_W-1:0] d_addr;
   logic [63:0]       d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [63:0]       d_rdata;
   logic              d_err;

   logic              mem_req;
   logic              mem_wr;
   logic [2:0]        mem_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic              mem_ack;
   logic              mem_rvalid;
   logic [63:0]       mem_rdata;
   logic              mem_err;

   modport slave (
      input  if_req, if_addr, if_kill,
      output if_ready, if_rvalid, if_rdata, if_err,
      input  d_req, d_wr, d_op, d_addr, d_wdata,
      output d_ready, d_rvalid, d_rdata, d_err,
      output mem_req, mem_wr, mem_op, mem_addr, mem_wdata,
      input  mem_ack, mem_rvalid, mem_rdata, mem_err
   );

   modport master (
      output if_req, if_addr, if_kill,
      input  if_ready, if_rvalid, if_rdata, if_err,
      output d_req, d_wr, d_op, d_addr, d_wdata,
      input  d_ready, d_rvalid, d_rdata, d_err,
      input  mem_req, mem_wr, mem_op, mem_addr, mem_wdata,
      output mem_ack, mem_rvalid, mem_rdata, mem_err
   );
endinterface

// File: rtl/ysyx_220066_membus_arb.sv
// Fetch/data arbiter for the single core memory port, one txn in flight.
// Define ARB_PERF_EN to add grant/stall performance counters.
module ysyx_220066_membus_arb #(
   parameter int STARVE_MAX = 4,
   parameter int ADDR_W     = 64
) (
   input  logic clk,
   input  logic rst,
`ifdef ARB_PERF_EN
   output logic [31:0] perf_i_cnt,
   output logic [31:0] perf_d_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   ysyx_220066_membus_arb_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [2:0] OP_WORD    = 3'b010;
   localparam logic [ADDR_W-1:0] FETCH_MASK =
      {{(ADDR_W-3){1'b1}}, 3'b000};

   state_t     state;
   logic       owner_i;
   logic       kill_flag;
   logic [3:0] starve_cnt;
   logic       addr_hi;

   logic idle;
   logic grant_i;
   logic grant_d;
   logic done;
   logic kill_now;

   always_comb begin
      idle     = (state == S_IDLE) && !rst;
      grant_i  = idle && bus.if_req && !bus.if_kill &&
                 (!bus.d_req || starve_cnt == STARVE_LIM);
      grant_d  = idle && bus.d_req && !grant_i;
      done     = bus.mem_rvalid &&
                 ((state == S_WAIT) ||
                  (state == S_REQ && bus.mem_ack));
      // a kill arriving with the response still suppresses it
      kill_now = kill_flag || (owner_i && bus.if_kill);
   end

   assign bus.if_ready = grant_i;
   assign bus.d_ready  = grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         owner_i       <= 1'b0;
         kill_flag     <= 1'b0;
         starve_cnt    <= '0;
         addr_hi       <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_wr    <= 1'b0;
         bus.mem_op    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rvalid <= 1'b0;
         bus.if_rdata  <= '0;
         bus.if_err    <= 1'b0;
         bus.d_rvalid  <= 1'b0;
         bus.d_rdata   <= '0;
         bus.d_err     <= 1'b0;
      end else begin
         bus.if_rvalid <= 1'b0;
         bus.if_err    <= 1'b0;
         bus.d_rvalid  <= 1'b0;
         bus.d_err     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               kill_flag <= 1'b0;
               if (!bus.if_req) starve_cnt <= '0;
               if (grant_i) begin
                  owner_i       <= 1'b1;
                  starve_cnt    <= '0;
                  bus.mem_req   <= 1'b1;
                  bus.mem_wr    <= 1'b0;
                  bus.mem_op    <= OP_WORD;
                  bus.mem_addr  <= bus.if_addr & FETCH_MASK;
                  bus.mem_wdata <= '0;
                  addr_hi       <= bus.if_addr[2];
                  state         <= S_REQ;
               end else if (grant_d) begin
                  if (bus.if_req && starve_cnt != 4'hf)
                     starve_cnt <= starve_cnt + 4'd1;
                  owner_i       <= 1'b0;
                  bus.mem_req   <= 1'b1;
                  bus.mem_wr    <= bus.d_wr;
                  bus.mem_op    <= bus.d_op;
                  bus.mem_addr  <= bus.d_addr;
                  bus.mem_wdata <= bus.d_wdata;
                  state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (owner_i && bus.if_kill) kill_flag <= 1'b1;
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  state <= bus.mem_rvalid ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (owner_i && bus.if_kill) kill_flag <= 1'b1;
               if (bus.mem_rvalid) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (done) begin
            kill_flag <= 1'b0;
            if (!owner_i) begin
               bus.d_rvalid <= 1'b1;
               bus.d_err    <= bus.mem_err;
               bus.d_rdata  <= bus.mem_rdata;
            end else if (!kill_now) begin
               bus.if_rvalid <= 1'b1;
               bus.if_err    <= bus.mem_err;
               bus.if_rdata  <= addr_hi ? bus.mem_rdata[63:32]
                                        : bus.mem_rdata[31:0];
            end
         end
      end
   end

`ifdef ARB_PERF_EN
   logic stall;
   assign stall = idle && ((bus.if_req && !grant_i) ||
                           (bus.d_req && !grant_d));

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_cnt     <= '0;
         perf_d_cnt     <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (grant_i) perf_i_cnt <= perf_i_cnt + 32'd1;
         if (grant_d) perf_d_cnt <= perf_d_cnt + 32'd1;
         if (stall)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_220066_membus_arb.sv
// Bench for ysyx_220066_membus_arb: directed plan steps, then random
// traffic against a transaction-level reference model.
module tb_ysyx_220066_membus_arb;
   localparam int SMAX = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_220066_membus_arb_if #(.ADDR_W(64)) bus ();

`ifdef ARB_PERF_EN
   logic [31:0] perf_i_cnt;
   logic [31:0] perf_d_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   ysyx_220066_membus_arb #(
      .STARVE_MAX(SMAX),
      .ADDR_W(64)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef ARB_PERF_EN
      .perf_i_cnt(perf_i_cnt),
      .perf_d_cnt(perf_d_cnt),
      .perf_stall_cnt(perf_stall_cnt),
`endif
      .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference model: the single in-flight transaction plus outputs
   bit          m_busy, m_acked, m_killed, m_own_i, m_hi;
   int          m_starve;
   bit          m_req, m_wr;
   logic [2:0]  m_op;
   logic [63:0] m_addr, m_wdata;
   bit          m_if_rv, m_if_err, m_d_rv, m_d_err;
   logic [31:0] m_if_rdata;
   logic [63:0] m_d_rdata;
   logic [31:0] m_pi, m_pd, m_ps;

   function automatic void model_reset();
      m_busy = 0; m_acked = 0; m_killed = 0; m_own_i = 0; m_hi = 0;
      m_starve = 0; m_req = 0; m_wr = 0; m_op = '0;
      m_addr = '0; m_wdata = '0;
      m_if_rv = 0; m_if_err = 0; m_d_rv = 0; m_d_err = 0;
      m_if_rdata = '0; m_d_rdata = '0;
      m_pi = '0; m_pd = '0; m_ps = '0;
   endfunction

   function automatic void predict(output bit gi, output bit gd);
      bit free;
      free = !rst && !m_busy;
      gi = free && bus.if_req && !bus.if_kill &&
           (!bus.d_req || m_starve == SMAX);
      gd = free && bus.d_req && !gi;
   endfunction

   function automatic void model_step();
      bit gi, gd, fin;
      if (rst) begin
         model_reset();
         return;
      end
      predict(gi, gd);
      m_if_rv = 0; m_if_err = 0; m_d_rv = 0; m_d_err = 0;
      if (!m_busy) begin
         if (gi) m_pi++;
         if (gd) m_pd++;
         if ((bus.if_req && !gi) || (bus.d_req && !gd)) m_ps++;
         if (!bus.if_req || gi) m_starve = 0;
         else if (gd && m_starve < 15) m_starve++;
         if (gi || gd) begin
            m_busy = 1; m_acked = 0; m_killed = 0;
            m_own_i = gi; m_req = 1;
            if (gi) begin
               m_wr = 0; m_op = 3'b010;
               m_addr = bus.if_addr & ~64'h7;
               m_hi = bus.if_addr[2];
            end else begin
               m_wr = bus.d_wr; m_op = bus.d_op;
               m_addr = bus.d_addr; m_wdata = bus.d_wdata;
            end
         end
      end else begin
         fin = bus.mem_rvalid && (m_acked || bus.mem_ack);
         if (m_own_i && bus.if_kill) m_killed = 1;
         if (bus.mem_ack && !m_acked) begin
            m_acked = 1;
            m_req = 0;
         end
         if (fin) begin
            m_busy = 0;
            if (!m_own_i) begin
               m_d_rv = 1; m_d_err = bus.mem_err;
               m_d_rdata = bus.mem_rdata;
            end else if (!m_killed) begin
               m_if_rv = 1; m_if_err = bus.mem_err;
               m_if_rdata = m_hi ? bus.mem_rdata[63:32]
                                 : bus.mem_rdata[31:0];
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      bit gi, gd;
      predict(gi, gd);
      chk("if_ready", 64'(bus.if_ready), 64'(gi));
      chk("d_ready", 64'(bus.d_ready), 64'(gd));
      chk("mem_req", 64'(bus.mem_req), 64'(m_req));
      if (m_req) begin
         chk("mem_wr", 64'(bus.mem_wr), 64'(m_wr));
         chk("mem_op", 64'(bus.mem_op), 64'(m_op));
         chk("mem_addr", bus.mem_addr, m_addr);
         if (!m_own_i) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("if_rvalid", 64'(bus.if_rvalid), 64'(m_if_rv));
      if (m_if_rv) begin
         chk("if_err", 64'(bus.if_err), 64'(m_if_err));
         chk("if_rdata", 64'(bus.if_rdata), 64'(m_if_rdata));
      end
      chk("d_rvalid", 64'(bus.d_rvalid), 64'(m_d_rv));
      if (m_d_rv) begin
         chk("d_err", 64'(bus.d_err), 64'(m_d_err));
         chk("d_rdata", bus.d_rdata, m_d_rdata);
      end
`ifdef ARB_PERF_EN
      chk("perf_i", 64'(perf_i_cnt), 64'(m_pi));
      chk("perf_d", 64'(perf_d_cnt), 64'(m_pd));
      chk("perf_stall", 64'(perf_stall_cnt), 64'(m_ps));
`endif
   endtask

   task automatic tick();
      #1;
      check_outputs();
      model_step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.if_req = 0; bus.if_addr = '0; bus.if_kill = 0;
      bus.d_req = 0; bus.d_wr = 0; bus.d_op = '0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ack = 0; bus.mem_rvalid = 0;
      bus.mem_rdata = '0; bus.mem_err = 0;
   endtask

   // memory answers every request at once; grants recorded in order
   task automatic run_grants(input int n, output string seq);
      int budget;
      budget = 0;
      seq = "";
      while (seq.len() < n && budget < 100) begin
         bus.mem_ack = bus.mem_req;
         bus.mem_rvalid = bus.mem_req;
         bus.mem_rdata = {$urandom, $urandom};
         #1;
         if (bus.if_ready) seq = {seq, "I"};
         if (bus.d_ready) seq = {seq, "D"};
         budget++;
         tick();
      end
      bus.mem_ack = 0;
      bus.mem_rvalid = 0;
   endtask

   task automatic chk_seq(input string tag, input string got,
                          input string exp);
      vectors++;
      assert (got == exp) else begin
         miscompares++;
         $error("FAIL %s: got %s expected %s", tag, got, exp);
      end
   endtask

   initial begin
      string seq;
      logic [31:0] r;
      model_reset();
      clear_inputs();
      rst = 1;
      @(negedge clk);
      tick();
      rst = 0;
      #1;
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_addr", bus.mem_addr, 64'd0);
      chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      tick();

      // single fetch from the upper word
      bus.if_req = 1; bus.if_addr = 64'h8000_0004;
      #1;
      chk("fetch_ready", 64'(bus.if_ready), 64'd1);
      tick();
      bus.if_req = 0;
      #1;
      chk("fetch_mem_addr", bus.mem_addr, 64'h8000_0000);
      chk("fetch_mem_op", 64'(bus.mem_op), 64'd2);
      bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0;
      tick();
      bus.mem_rvalid = 1; bus.mem_rdata = 64'h1111_1111_2222_2222;
      tick();
      bus.mem_rvalid = 0;
      #1;
      chk("fetch_rvalid", 64'(bus.if_rvalid), 64'd1);
      chk("fetch_rdata", 64'(bus.if_rdata), 64'h1111_1111);
      tick();

      // store held through three un-acked cycles
      bus.d_req = 1; bus.d_wr = 1; bus.d_op = 3'd3;
      bus.d_addr = 64'h8000_1000; bus.d_wdata = 64'hDEAD;
      tick();
      bus.d_req = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("store_hold_req", 64'(bus.mem_req), 64'd1);
         chk("store_hold_wr", 64'(bus.mem_wr), 64'd1);
         tick();
      end
      bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0;
      tick();
      bus.mem_rvalid = 1;
      tick();
      bus.mem_rvalid = 0;
      #1;
      chk("store_rvalid", 64'(bus.d_rvalid), 64'd1);
      chk("store_err", 64'(bus.d_err), 64'd0);
      tick();

      // contention
      bus.if_req = 1; bus.if_addr = 64'h8000_0100;
      bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 64'h8000_3000;
      run_grants(6, seq);
      chk_seq("grant_order", seq, "DDIDDI");
      bus.if_req = 0; bus.d_req = 0;
      bus.mem_ack = 1; bus.mem_rvalid = 1;
      tick();
      clear_inputs();
      tick();

      // kill during WAIT, then errored load
      bus.if_req = 1; bus.if_addr = 64'h8000_0010;
      tick();
      bus.if_req = 0; bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0; bus.if_kill = 1;
      tick();
      bus.if_kill = 0; bus.d_req = 1; bus.d_wr = 0;
      bus.d_op = 3'b011; bus.d_addr = 64'h8000_2000;
      bus.mem_rvalid = 1; bus.mem_rdata = 64'h5555_6666_7777_8888;
      tick();
      bus.mem_rvalid = 0;
      #1;
      chk("kill_no_rvalid", 64'(bus.if_rvalid), 64'd0);
      chk("kill_d_grant", 64'(bus.d_ready), 64'd1);
      tick();
      bus.d_req = 0; bus.mem_ack = 1; bus.mem_rvalid = 1;
      bus.mem_err = 1; bus.mem_rdata = 64'h0123_4567_89ab_cdef;
      tick();
      bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_err = 0;
      bus.d_req = 1;
      #1;
      chk("err_rvalid", 64'(bus.d_rvalid), 64'd1);
      chk("err_flag", 64'(bus.d_err), 64'd1);
      chk("err_idle_grant", 64'(bus.d_ready), 64'd1);
      tick();
      bus.d_req = 0; bus.mem_ack = 1; bus.mem_rvalid = 1;
      tick();
      clear_inputs();
      tick();

      // reset mid-WAIT, stale response afterwards
      bus.if_req = 1; bus.if_addr = 64'h8000_0020;
      tick();
      bus.if_req = 0; bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0;
      tick();
      rst = 1;
      tick();
      rst = 0; bus.mem_rvalid = 1;
      tick();
      bus.mem_rvalid = 0;
      #1;
      chk("stale_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      chk("stale_d_rvalid", 64'(bus.d_rvalid), 64'd0);
      chk("stale_mem_req", 64'(bus.mem_req), 64'd0);
      chk("stale_mem_addr", bus.mem_addr, 64'd0);
      chk("stale_if_rdata", 64'(bus.if_rdata), 64'd0);
      tick();

      // reset clears the starvation count
      bus.if_req = 1; bus.d_req = 1;
      run_grants(4, seq);
      chk_seq("pre_rst_order", seq, "DDID");
      rst = 1;
      tick();
      rst = 0;
      run_grants(3, seq);
      chk_seq("post_rst_order", seq, "DDI");
      bus.if_req = 0; bus.d_req = 0;
      bus.mem_ack = 1; bus.mem_rvalid = 1;
      tick();
      clear_inputs();
      tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         r = $urandom;
         bus.if_req = $urandom_range(0, 1) == 1;
         bus.if_addr = {$urandom, r[31:2], 2'b00};
         bus.if_kill = $urandom_range(0, 9) == 0;
         bus.d_req = $urandom_range(0, 1) == 1;
         bus.d_wr = $urandom_range(0, 1) == 1;
         bus.d_op = 3'($urandom);
         bus.d_addr = {$urandom, $urandom};
         bus.d_wdata = {$urandom, $urandom};
         bus.mem_ack = $urandom_range(0, 9) < 4;
         bus.mem_rvalid = $urandom_range(0, 9) < 4;
         bus.mem_err = $urandom_range(0, 4) == 0;
         bus.mem_rdata = {$urandom, $urandom};
         tick();
      end
      rst = 0;
      clear_inputs();
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
